// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache requesters, the arbiter and the shared data memory.
// The master view belongs to the arbiter, which drives the memory bus. The slave view
// belongs to the requesters and the memory model.
interface mem_arbiter_if #(
    parameter int unsigned BLOCKSIZE = 4
);
    localparam int unsigned IDXW = $clog2(BLOCKSIZE);

    // Requester side
    logic            IReq;
    logic            DReq;
    logic            IWrite;
    logic            DWrite;
    logic            IBurst;
    logic            DBurst;
    logic [31:0]     IAddr;
    logic [31:0]     DAddr;
    logic [31:0]     IWD;
    logic [31:0]     DWD;
    logic            IGnt;
    logic            DGnt;
    logic [IDXW-1:0] WordIdx;
    logic [31:0]     RData;
    logic            IRValid;
    logic            DRValid;
    logic            IDone;
    logic            DDone;

    // Memory side
    logic [31:0]     MemA;
    logic [31:0]     MemWD;
    logic            MemWE;
    logic            MemRE;
    logic            MemHSEL;
    logic [31:0]     MemRD;
    logic            MemValid;

    modport master (
        input  IReq, DReq, IWrite, DWrite, IBurst, DBurst, IAddr, DAddr, IWD, DWD,
        input  MemRD, MemValid,
        output IGnt, DGnt, WordIdx, RData, IRValid, DRValid, IDone, DDone,
        output MemA, MemWD, MemWE, MemRE, MemHSEL
    );

    modport slave (
        output IReq, DReq, IWrite, DWrite, IBurst, DBurst, IAddr, DAddr, IWD, DWD,
        output MemRD, MemValid,
        input  IGnt, DGnt, WordIdx, RData, IRValid, DRValid, IDone, DDone,
        input  MemA, MemWD, MemWE, MemRE, MemHSEL
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and burst sequencer that shares one data memory between the I-side and
// D-side caches. It runs one single-word or block-length transfer at a time. Read data is
// returned in the same cycle as the address.
module mem_arbiter #(
    parameter int unsigned BLOCKSIZE = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);
    localparam int unsigned IDXW = $clog2(BLOCKSIZE);

    // Bursts are block-aligned. Single words are only word-aligned.
    localparam logic [31:0] BlkMask  = ~(32'(BLOCKSIZE) * 32'd4 - 32'd1);
    localparam logic [31:0] WordMask = ~32'h3;

    typedef enum logic [1:0] {StIdle, StXferI, StXferD} state_e;

    state_e          state_q, state_d;
    logic [IDXW-1:0] count_q, count_d;
    logic            last_d_q, last_d_d;
    logic [31:0]     base_q, base_d;
    logic            write_q, write_d;
    logic            burst_q, burst_d;

    logic            is_d;
    logic            last_word;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            count_q  <= '0;
            last_d_q <= 1'b0;
            base_q   <= '0;
            write_q  <= 1'b0;
            burst_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            last_d_q <= last_d_d;
            base_q   <= base_d;
            write_q  <= write_d;
            burst_q  <= burst_d;
        end
    end

    assign is_d      = (state_q == StXferD);
    assign last_word = burst_q ? (count_q == IDXW'(BLOCKSIZE - 1)) : (count_q == '0);

    // Arbitration, word sequencing and all bus outputs
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        last_d_d = last_d_q;
        base_d   = base_q;
        write_d  = write_q;
        burst_d  = burst_q;

        bus.IGnt    = 1'b0;
        bus.DGnt    = 1'b0;
        bus.WordIdx = '0;
        bus.RData   = bus.MemRD;
        bus.IRValid = 1'b0;
        bus.DRValid = 1'b0;
        bus.IDone   = 1'b0;
        bus.DDone   = 1'b0;
        bus.MemA    = '0;
        bus.MemWD   = '0;
        bus.MemWE   = 1'b0;
        bus.MemRE   = 1'b0;
        bus.MemHSEL = 1'b0;

        unique case (state_q)
            StIdle: begin
                count_d = '0;
                // On a tie the side that was not granted last wins.
                if (bus.IReq && (!bus.DReq || last_d_q)) begin
                    state_d  = StXferI;
                    last_d_d = 1'b0;
                    base_d   = bus.IAddr & (bus.IBurst ? BlkMask : WordMask);
                    write_d  = bus.IWrite;
                    burst_d  = bus.IBurst;
                end else if (bus.DReq) begin
                    state_d  = StXferD;
                    last_d_d = 1'b1;
                    base_d   = bus.DAddr & (bus.DBurst ? BlkMask : WordMask);
                    write_d  = bus.DWrite;
                    burst_d  = bus.DBurst;
                end
            end
            StXferI, StXferD: begin
                bus.MemHSEL = 1'b1;
                bus.MemRE   = !write_q;
                bus.MemWE   = write_q;
                // Base is block-aligned, so OR-ing the index in can never carry out of the block.
                bus.MemA    = base_q | {{(30 - IDXW){1'b0}}, count_q, 2'b00};
                bus.MemWD   = is_d ? bus.DWD : bus.IWD;
                bus.WordIdx = count_q;
                bus.IGnt    = !is_d;
                bus.DGnt    = is_d;
                if (bus.MemValid) begin
                    bus.IRValid = !is_d && !write_q;
                    bus.DRValid = is_d && !write_q;
                    if (last_word) begin
                        bus.IDone = !is_d;
                        bus.DDone = is_d;
                        count_d   = '0;
                        state_d   = StIdle;
                    end else begin
                        count_d = count_q + IDXW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                count_d = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transfer-level model checked against the DUT every
// cycle, plus literal expectations for each scenario.
module tb_mem_arbiter;
    localparam int unsigned BLOCKSIZE = 4;

    logic clk = 1'b0;
    logic reset;

    mem_arbiter_if #(.BLOCKSIZE(BLOCKSIZE)) bus ();

    mem_arbiter #(.BLOCKSIZE(BLOCKSIZE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model: unwritten words read back as a fixed pattern of their index
    logic [31:0] mem    [256];
    int          wr_cnt [256];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [7:0] idx;
        idx = a[9:2];
        if (wr_cnt[idx] != 0) return mem[idx];
        if (idx == 8'h41) return 32'hDEAD_BEEF;
        return {16'hC0DE, 8'h00, idx};
    endfunction

    always @(posedge clk) begin
        if (bus.MemHSEL && bus.MemWE && bus.MemValid) begin
            mem[bus.MemA[9:2]]    <= bus.MemWD;
            wr_cnt[bus.MemA[9:2]] <= wr_cnt[bus.MemA[9:2]] + 1;
        end
    end

    assign bus.MemRD = mem_word(bus.MemA);
    assign bus.IWD   = 32'h5A5A_0000 | 32'(bus.WordIdx);
    assign bus.DWD   = 32'hA5A5_0000 | 32'(bus.WordIdx);

    // Transfer-level model: one active transfer with its aligned base, length and word number
    bit          m_valid  = 1'b0;
    bit          m_busy   = 1'b0;
    bit          m_side   = 1'b0;  // 1 = D side
    bit          m_last_d = 1'b0;
    bit          m_write  = 1'b0;
    logic [31:0] m_base   = '0;
    int          m_nwords = 1;
    int          m_k      = 0;

    function automatic bit pick_d(input bit ireq, input bit dreq, input bit last_d);
        if (ireq && dreq) return !last_d;
        return dreq;
    endfunction

    function automatic logic [31:0] align(input logic [31:0] a, input bit burst);
        int unsigned span;
        span = burst ? BLOCKSIZE * 4 : 4;
        return a - (a % span);
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_valid  <= 1'b1;
            m_busy   <= 1'b0;
            m_k      <= 0;
            m_last_d <= 1'b0;
        end else if (!m_busy) begin
            if (bus.IReq || bus.DReq) begin
                m_busy   <= 1'b1;
                m_k      <= 0;
                m_side   <= pick_d(bus.IReq, bus.DReq, m_last_d);
                m_last_d <= pick_d(bus.IReq, bus.DReq, m_last_d);
                if (pick_d(bus.IReq, bus.DReq, m_last_d)) begin
                    m_base   <= align(bus.DAddr, bus.DBurst);
                    m_write  <= bus.DWrite;
                    m_nwords <= bus.DBurst ? BLOCKSIZE : 1;
                end else begin
                    m_base   <= align(bus.IAddr, bus.IBurst);
                    m_write  <= bus.IWrite;
                    m_nwords <= bus.IBurst ? BLOCKSIZE : 1;
                end
            end
        end else if (bus.MemValid) begin
            if (m_k + 1 == m_nwords) begin
                m_busy <= 1'b0;
                m_k    <= 0;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Compare every DUT output against the model just before each rising edge
    task automatic compare_loop();
        logic [31:0] exp_a;
        bit          fire;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                exp_a = m_busy ? m_base + 32'(4 * m_k) : 32'h0;
                fire  = m_busy && bus.MemValid;
                check("m_igSnt", {31'b0, bus.IGnt}, {31'b0, m_busy && !m_side});
                check("m_dgnt", {31'b0, bus.DGnt}, {31'b0, m_busy && m_side});
                check("m_hsel", {31'b0, bus.MemHSEL}, {31'b0, m_busy});
                check("m_we", {31'b0, bus.MemWE}, {31'b0, m_busy && m_write});
                check("m_re", {31'b0, bus.MemRE}, {31'b0, m_busy && !m_write});
                check("m_addr", bus.MemA, exp_a);
                check("m_widx", 32'(bus.WordIdx), m_busy ? 32'(m_k) : 32'h0);
                check("m_wd", bus.MemWD, !m_busy ? 32'h0 : (m_side ? bus.DWD : bus.IWD));
                check("m_irv", {31'b0, bus.IRValid}, {31'b0, fire && !m_side && !m_write});
                check("m_drv", {31'b0, bus.DRValid}, {31'b0, fire && m_side && !m_write});
                check("m_idone", {31'b0, bus.IDone},
                      {31'b0, fire && !m_side && (m_k + 1 == m_nwords)});
                check("m_ddone", {31'b0, bus.DDone},
                      {31'b0, fire && m_side && (m_k + 1 == m_nwords)});
                if (fire && !m_write) check("m_rdata", bus.RData, mem_word(exp_a));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          grant_seq [8] = '{2, 0, 1, 0, 2, 0, 1, 0};
    bit          st_valid  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] st_addr   [5] = '{32'h300, 32'h304, 32'h304, 32'h308, 32'h30C};

    initial begin
        reset        = 1'b0;
        bus.IReq     = 1'b0;
        bus.DReq     = 1'b0;
        bus.IWrite   = 1'b0;
        bus.DWrite   = 1'b0;
        bus.IBurst   = 1'b0;
        bus.DBurst   = 1'b0;
        bus.IAddr    = '0;
        bus.DAddr    = '0;
        bus.MemValid = 1'b1;
        fork
            compare_loop();
        join_none

        tick();
        tick();
        @(negedge clk);
        check("rst_igSnt", {31'b0, bus.IGnt}, 32'h0);
        check("rst_hsel", {31'b0, bus.MemHSEL}, 32'h0);
        reset = 1'b1;
        tick();

        // Single-word read on the D side
        bus.DReq  = 1'b1;
        bus.DAddr = 32'h104;
        tick();
        @(negedge clk);
        check("t1_addr", bus.MemA, 32'h104);
        check("t1_re", {31'b0, bus.MemRE}, 32'h1);
        check("t1_rvalid", {31'b0, bus.DRValid}, 32'h1);
        check("t1_rdata", bus.RData, 32'hDEAD_BEEF);
        check("t1_done", {31'b0, bus.DDone}, 32'h1);
        tick();
        bus.DReq = 1'b0;
        @(negedge clk);
        check("t1_idle", {31'b0, bus.DGnt | bus.MemHSEL}, 32'h0);

        // Burst read from an unaligned address on the I side
        bus.IReq   = 1'b1;
        bus.IAddr  = 32'h20C;
        bus.IBurst = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            @(negedge clk);
            check("t2_addr", bus.MemA, 32'h200 + 32'(4 * (c - 1)));
            check("t2_widx", 32'(bus.WordIdx), 32'(c - 1));
            check("t2_done", {31'b0, bus.IDone}, {31'b0, c == 4});
            check("t2_dgnt", {31'b0, bus.DGnt}, 32'h0);
        end
        tick();
        bus.IReq   = 1'b0;
        bus.IBurst = 1'b0;
        @(negedge clk);
        check("t2_idle", {31'b0, bus.IGnt}, 32'h0);

        // Tie from reset: D first, then alternate with one idle cycle between
        reset = 1'b0;
        tick();
        reset     = 1'b1;
        bus.IReq  = 1'b1;
        bus.DReq  = 1'b1;
        bus.IAddr = 32'h10;
        bus.DAddr = 32'h14;
        for (int c = 0; c < 8; c++) begin
            tick();
            @(negedge clk);
            check("t3_order", bus.DGnt ? 32'd2 : (bus.IGnt ? 32'd1 : 32'd0), 32'(grant_seq[c]));
        end
        bus.IReq = 1'b0;
        bus.DReq = 1'b0;
        tick();

        // D burst write with a stall on the second memory cycle
        bus.DReq   = 1'b1;
        bus.DWrite = 1'b1;
        bus.DBurst = 1'b1;
        bus.DAddr  = 32'h300;
        for (int c = 0; c < 5; c++) begin
            tick();
            bus.MemValid = st_valid[c];
            @(negedge clk);
            check("t4_addr", bus.MemA, st_addr[c]);
            check("t4_we", {31'b0, bus.MemWE}, 32'h1);
            check("t4_done", {31'b0, bus.DDone}, {31'b0, c == 4});
        end
        tick();
        bus.MemValid = 1'b1;
        bus.DReq     = 1'b0;
        bus.DWrite   = 1'b0;
        bus.DBurst   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t4_wcnt", 32'(wr_cnt[8'hC0 + i]), 32'd1);
            check("t4_wdata", mem[8'hC0 + i], 32'hA5A5_0000 | 32'(i));
        end

        // Reset in the middle of an I burst
        bus.IReq   = 1'b1;
        bus.IBurst = 1'b1;
        bus.IAddr  = 32'h400;
        tick();
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t5_widx", 32'(bus.WordIdx), 32'd2);
        tick();
        reset      = 1'b1;
        bus.IReq   = 1'b0;
        bus.IBurst = 1'b0;
        bus.DReq   = 1'b1;
        bus.DAddr  = 32'h108;
        @(negedge clk);
        check("t5_off", {28'b0, bus.IGnt, bus.DGnt, bus.MemWE, bus.MemHSEL}, 32'h0);
        check("t5_nodone", {31'b0, bus.IDone}, 32'h0);
        tick();
        @(negedge clk);
        check("t5_dgnt", {31'b0, bus.DGnt}, 32'h1);
        check("t5_addr", bus.MemA, 32'h108);
        tick();
        bus.DReq = 1'b0;

        // I request dropped mid-burst; the burst still completes
        bus.IReq   = 1'b1;
        bus.IBurst = 1'b1;
        bus.IAddr  = 32'h504;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 2) bus.IReq = 1'b0;
            @(negedge clk);
            check("t6_gnt", {31'b0, bus.IGnt}, 32'h1);
            check("t6_addr", bus.MemA, 32'h500 + 32'(4 * (c - 1)));
            check("t6_done", {31'b0, bus.IDone}, {31'b0, c == 4});
        end
        tick();
        bus.IBurst = 1'b0;
        @(negedge clk);
        check("t6_idle", {31'b0, bus.IGnt}, 32'h0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before 200000");
        $fatal(1, "timeout");
    end
endmodule
